// File: rtl/hci_mem_bank_responder.sv
// TCDM bank responder: grants hci mem requests, accesses a word array, returns r_* after LATENCY cycles.
// Optional HCI_MEM_RESP_STALL_EN: LFSR-driven pseudo-random grant stalls.
module hci_mem_bank_responder #(
  parameter int DW      = 32,
  parameter int BW      = 8,
  parameter int AW      = 10,
  parameter int IW      = 8,
  parameter int LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [AW-1:0]    add_i,
  input  logic             wen_i,
  input  logic [DW-1:0]    data_i,
  input  logic [DW/BW-1:0] be_i,
  input  logic [IW-1:0]    id_i,
  output logic [DW-1:0]    r_data_o,
  output logic [IW-1:0]    r_id_o,
  output logic             r_valid_o
);
  localparam int NB = DW / BW;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $fatal(1, "hci_mem_bank_responder: LATENCY must be 1..4");
  end

  typedef struct packed {
    logic          vld;
    logic          rd;
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } stage_t;

  logic [DW-1:0]              mem_q [2**AW];
  stage_t [LATENCY-1:0]       pipe_q;
  stage_t                     stage0_d;
  logic                       acc;

`ifdef HCI_MEM_RESP_STALL_EN
  // Fibonacci LFSR, taps 16,14,13,11; only rst_i reseeds it.
  logic [15:0] lfsr_q, lfsr_d;
  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end

  assign gnt_o = req_i & ~lfsr_q[0];
`else
  assign gnt_o = req_i;
`endif

  assign acc = req_i & gnt_o;

  // Storage is never reset; clear_i does not block the write.
  always_ff @(posedge clk_i) begin
    if (acc && !wen_i) begin
      for (int k = 0; k < NB; k++) begin
        if (be_i[k]) mem_q[add_i][k*BW +: BW] <= data_i[k*BW +: BW];
      end
    end
  end

  // Invalid stages carry zero id/data so the outputs idle at 0.
  always_comb begin
    stage0_d = '0;
    if (acc && !clear_i) begin
      stage0_d.vld  = 1'b1;
      stage0_d.rd   = wen_i;
      stage0_d.id   = id_i;
      stage0_d.data = wen_i ? mem_q[add_i] : '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_q <= '0;
    end else if (clear_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= stage0_d;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign r_valid_o = pipe_q[LATENCY-1].vld;
  assign r_id_o    = pipe_q[LATENCY-1].id;
  assign r_data_o  = pipe_q[LATENCY-1].rd ? pipe_q[LATENCY-1].data : '0;

endmodule

// File: tb/tb_hci_mem_bank_responder.sv
// Bench: three responders (LATENCY 1/3/4) on shared stimulus, checked by a per-instance scoreboard.
module tb_hci_mem_bank_responder;
  logic        clk = 1'b0;
  logic        rst, clear, req, wen;
  logic [9:0]  add;
  logic [31:0] data;
  logic [3:0]  be;
  logic [7:0]  id;

  logic        rv [3];
  logic        gn [3];
  logic [31:0] rd [3];
  logic [7:0]  ri [3];

  typedef struct { int due; logic [7:0] id; logic [31:0] data; } exp_t;
  exp_t        q [3][$];
  int          lat [3] = '{1, 3, 4};
  logic [31:0] mdl [1024];
  int          cyc = 0, nasrt = 0, nfail = 0, ngrant = 0;
  int          nresp [3] = '{0, 0, 0};
  logic [31:0] last_data [3];
  logic [7:0]  last_id [3];
  logic        last_acc = 1'b0;
`ifdef HCI_MEM_RESP_STALL_EN
  logic [15:0] lfsr = 16'hACE1;
`endif

  always #5 clk = ~clk;

  hci_mem_bank_responder #(.LATENCY(1)) u_l1 (.clk_i(clk), .rst_i(rst), .clear_i(clear), .req_i(req),
    .gnt_o(gn[0]), .add_i(add), .wen_i(wen), .data_i(data), .be_i(be), .id_i(id),
    .r_data_o(rd[0]), .r_id_o(ri[0]), .r_valid_o(rv[0]));
  hci_mem_bank_responder #(.LATENCY(3)) u_l3 (.clk_i(clk), .rst_i(rst), .clear_i(clear), .req_i(req),
    .gnt_o(gn[1]), .add_i(add), .wen_i(wen), .data_i(data), .be_i(be), .id_i(id),
    .r_data_o(rd[1]), .r_id_o(ri[1]), .r_valid_o(rv[1]));
  hci_mem_bank_responder #(.LATENCY(4)) u_l4 (.clk_i(clk), .rst_i(rst), .clear_i(clear), .req_i(req),
    .gnt_o(gn[2]), .add_i(add), .wen_i(wen), .data_i(data), .be_i(be), .id_i(id),
    .r_data_o(rd[2]), .r_id_o(ri[2]), .r_valid_o(rv[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic stall_bit();
`ifdef HCI_MEM_RESP_STALL_EN
    return lfsr[0];
`else
    return 1'b0;
`endif
  endfunction

  // Reference model: accept, memory update, expected response push.
  always @(posedge clk) begin
    logic        g;
    logic [31:0] rdv;
    cyc++;
    last_acc = 1'b0;
    if (rst) begin
      for (int j = 0; j < 3; j++) q[j].delete();
`ifdef HCI_MEM_RESP_STALL_EN
      lfsr = 16'hACE1;
`endif
    end else begin
      g = req && !stall_bit();
      last_acc = g;
      if (clear) for (int j = 0; j < 3; j++) q[j].delete();
      if (g) begin
        ngrant++;
        rdv = mdl[add];
        if (!wen) for (int k = 0; k < 4; k++) if (be[k]) mdl[add][k*8 +: 8] = data[k*8 +: 8];
        if (!clear) for (int j = 0; j < 3; j++) q[j].push_back('{cyc + lat[j] - 1, id, wen ? rdv : 32'h0});
      end
`ifdef HCI_MEM_RESP_STALL_EN
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
`endif
    end
  end

  // Response monitor, sampled mid-cycle.
  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) begin
      logic ev;
      exp_t e;
      ev = !rst && q[j].size() > 0 && q[j][0].due == cyc;
      chk("r_valid", {31'h0, rv[j]}, {31'h0, ev});
      chk("gnt", {31'h0, gn[j]}, {31'h0, !rst && req && !stall_bit()});
      if (ev) begin
        e = q[j].pop_front();
        chk("r_id", {24'h0, ri[j]}, {24'h0, e.id});
        chk("r_data", rd[j], e.data);
        last_data[j] = rd[j];
        last_id[j]   = ri[j];
        nresp[j]++;
      end else begin
        chk("r_id_idle", {24'h0, ri[j]}, 32'h0);
        chk("r_data_idle", rd[j], 32'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic w, input logic [9:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [7:0] i);
    int n = 0;
    req = 1'b1; wen = w; add = a; data = d; be = b; id = i;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 100);
    if (!last_acc) chk("issue_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n);
    req = 1'b0; wen = 1'b1; be = 4'h0;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0 [3];
    int g0;
    rst = 1'b1; clear = 1'b0; req = 1'b0; wen = 1'b1; add = '0; data = '0; be = '0; id = '0;
    repeat (2) tick();
    for (int j = 0; j < 3; j++) begin
      chk("rst_r_valid", {31'h0, rv[j]}, 32'h0);
      chk("rst_r_data", rd[j], 32'h0);
      chk("rst_r_id", {24'h0, ri[j]}, 32'h0);
    end
    rst = 1'b0;
    tick();

    // Write then read back.
    issue(1'b0, 10'd5, 32'hDEADBEEF, 4'hF, 8'd3);
    issue(1'b1, 10'd5, 32'h0, 4'h0, 8'd7);
    idle(6);
    chk("wr_rd_data", last_data[0], 32'hDEADBEEF);
    chk("wr_rd_id", {24'h0, last_id[0]}, 32'd7);

    // Byte enables, plus a be=0 no-op write that still responds.
    issue(1'b0, 10'd9, 32'h11223344, 4'hF, 8'd1);
    issue(1'b0, 10'd9, 32'hAABBCCDD, 4'b0101, 8'd2);
    issue(1'b0, 10'd9, 32'hFFFFFFFF, 4'b0000, 8'd3);
    issue(1'b1, 10'd9, 32'h0, 4'hF, 8'd4);
    idle(6);
    chk("be_data", last_data[0], 32'h11BB33DD);

    // Burst of back-to-back reads.
    for (int a = 0; a < 8; a++) issue(1'b0, 10'(a), 32'(a), 4'hF, 8'(a));
    idle(6);
    for (int j = 0; j < 3; j++) r0[j] = nresp[j];
    for (int a = 0; a < 8; a++) issue(1'b1, 10'(a), 32'h0, 4'h0, 8'(a));
    idle(6);
    chk("burst_count_l3", nresp[1] - r0[1], 32'd8);
    chk("burst_last_l3", last_data[1], 32'd7);

    // Flush with two reads in flight.
    for (int j = 0; j < 3; j++) r0[j] = nresp[j];
    issue(1'b1, 10'd1, 32'h0, 4'h0, 8'd10);
    issue(1'b1, 10'd2, 32'h0, 4'h0, 8'd11);
    req = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    issue(1'b1, 10'd3, 32'h0, 4'h0, 8'd12);
    idle(6);
    chk("flush_count_l4", nresp[2] - r0[2], 32'd1);
    chk("flush_id_l4", {24'h0, last_id[2]}, 32'd12);
    chk("flush_data_l4", last_data[2], 32'd3);

    // Asynchronous reset with responses in flight.
    issue(1'b0, 10'd20, 32'h5A5A1234, 4'hF, 8'd1);
    idle(6);
    issue(1'b1, 10'd20, 32'h0, 4'h0, 8'd21);
    issue(1'b1, 10'd20, 32'h0, 4'h0, 8'd22);
    req = 1'b0;
    #1 rst = 1'b1;
    #1;
    for (int j = 0; j < 3; j++) begin
      chk("arst_r_valid", {31'h0, rv[j]}, 32'h0);
      chk("arst_r_data", rd[j], 32'h0);
      chk("arst_r_id", {24'h0, ri[j]}, 32'h0);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int j = 0; j < 3; j++) r0[j] = nresp[j];
    idle(6);
    chk("arst_no_resp_l4", nresp[2] - r0[2], 32'd0);
    issue(1'b1, 10'd20, 32'h0, 4'h0, 8'd23);
    idle(6);
    chk("arst_mem_kept_l4", last_data[2], 32'h5A5A1234);

`ifdef HCI_MEM_RESP_STALL_EN
    // Held request: grant pattern checked each cycle by the monitor.
    g0 = ngrant;
    for (int j = 0; j < 3; j++) r0[j] = nresp[j];
    req = 1'b1; wen = 1'b1; add = 10'd5; id = 8'h55; be = 4'h0;
    repeat (64) tick();
    idle(8);
    for (int j = 0; j < 3; j++) chk("stall_resp_eq_gnt", nresp[j] - r0[j], ngrant - g0);
    chk("stall_some_stalls", {31'h0, (ngrant - g0) < 64}, 32'h1);
`else
    g0 = ngrant;
    for (int j = 0; j < 3; j++) r0[j] = nresp[j];
    req = 1'b1; wen = 1'b1; add = 10'd5; id = 8'h55; be = 4'h0;
    repeat (16) tick();
    idle(8);
    for (int j = 0; j < 3; j++) chk("held_resp_count", nresp[j] - r0[j], 32'd16);
    chk("held_grant_count", ngrant - g0, 32'd16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end
endmodule
